// File: rtl/uart_pkg.sv
// Shared register map, bit positions and serializer states for the UART TX engine.
package uart_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_INTCTL = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_BAUD   = 2'd3;

  // STATUS bit positions
  localparam int ST_EN      = 0;
  localparam int ST_PAR_EN  = 1;
  localparam int ST_PAR_ODD = 2;
  localparam int ST_STOP2   = 3;
  localparam int ST_FLUSH   = 4;
  localparam int ST_BUSY    = 5;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 7;

  // INTCTL bit positions
  localparam int IC_EMPTY_IE  = 0;
  localparam int IC_THR_IE    = 1;
  localparam int IC_OVF_IE    = 2;
  localparam int IC_OVF       = 3;
  localparam int IC_THRESH_LO = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush and same-cycle push+pop (push accepted when full if popping).
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // flush beats a same-cycle push; a pop frees the slot a full-FIFO push needs
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit peripheral: CPU register file, TX FIFO, baud counter, serializer FSM, interrupt.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    ADDR,
  input  logic          NCS,
  input  logic          NW,
  input  logic          NO,
  input  logic [7:0]    WDATA,
  output logic [7:0]    RDATA,
  output logic          NINT,
  output logic [LW-1:0] LEVEL,
  output logic          TX
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // control / interrupt registers
  logic             en_q, par_en_q, par_odd_q, stop2_q;
  logic             empty_ie_q, thr_ie_q, ovf_ie_q, ovf_q;
  logic [3:0]       thresh_q;
  logic [DIV_W-1:0] baud_q;

  // serializer state
  tx_state_t            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 fpar_en_q, fpar_en_d;
  logic                 fstop2_q, fstop2_d;
  logic                 tx_q, tx_d;

  logic                 wr_en, rd_en, wr_status, wr_intctl, wr_data, wr_baud;
  logic                 flush, push, pop, ovf_set, bit_end, busy, thr_hit;
  logic                 fifo_full, fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic [DATA_BITS-1:0] head;

  assign wr_en     = ~NCS & ~NW;
  assign rd_en     = ~NCS & ~NO;
  assign wr_status = wr_en & (ADDR == ADDR_STATUS);
  assign wr_intctl = wr_en & (ADDR == ADDR_INTCTL);
  assign wr_data   = wr_en & (ADDR == ADDR_DATA);
  assign wr_baud   = wr_en & (ADDR == ADDR_BAUD);
  assign flush     = wr_status & WDATA[ST_FLUSH];
  assign push      = wr_data & en_q;
  assign ovf_set   = push & fifo_full & ~pop & ~flush;
  assign busy      = (state_q != IDLE);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (WDATA[DATA_BITS-1:0]),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // CPU-visible registers; BAUD is frozen while the engine is enabled
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en_q       <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      empty_ie_q <= 1'b0;
      thr_ie_q   <= 1'b0;
      ovf_ie_q   <= 1'b0;
      ovf_q      <= 1'b0;
      thresh_q   <= '0;
      baud_q     <= '0;
    end else begin
      if (wr_status) begin
        en_q      <= WDATA[ST_EN];
        par_en_q  <= WDATA[ST_PAR_EN];
        par_odd_q <= WDATA[ST_PAR_ODD];
        stop2_q   <= WDATA[ST_STOP2];
      end
      if (wr_intctl) begin
        empty_ie_q <= WDATA[IC_EMPTY_IE];
        thr_ie_q   <= WDATA[IC_THR_IE];
        ovf_ie_q   <= WDATA[IC_OVF_IE];
        thresh_q   <= WDATA[IC_THRESH_LO +: 4];
      end
      if (wr_intctl & WDATA[IC_OVF]) ovf_q <= 1'b0;
      else if (ovf_set)              ovf_q <= 1'b1;
      if (wr_baud & ~en_q) baud_q <= DIV_W'(WDATA);
    end
  end

  // serializer state register; TX is registered so the pin never glitches
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      fpar_en_q <= 1'b0;
      fstop2_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      fpar_en_q <= fpar_en_d;
      fstop2_q  <= fstop2_d;
      tx_q      <= tx_d;
    end
  end

  // next-state: each bit lasts BAUD+1 cycles; frame format is latched at pop
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    fpar_en_d = fpar_en_q;
    fstop2_d  = fstop2_q;
    pop       = 1'b0;
    bit_end   = (cnt_q == '0);
    if (state_q != IDLE && !bit_end) cnt_d = cnt_q - DIV_W'(1);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_q && !fifo_empty) begin
          pop       = 1'b1;
          shift_d   = head;
          par_bit_d = par_odd_q ? ~^head : ^head;
          fpar_en_d = par_en_q;
          fstop2_d  = stop2_q;
          cnt_d     = baud_q;
          bit_d     = '0;
          state_d   = START;
        end
      end
      START: if (bit_end) begin
        cnt_d   = baud_q;
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        cnt_d   = baud_q;
        shift_d = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = fpar_en_q ? PARITY : STOP;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      PARITY: if (bit_end) begin
        cnt_d   = baud_q;
        bit_d   = '0;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        if (fstop2_q && bit_q == 3'd0) begin
          cnt_d = baud_q;
          bit_d = 3'd1;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  // read mux, gated by chip select and output enable
  always_comb begin
    RDATA = '0;
    if (rd_en) begin
      unique case (ADDR)
        ADDR_STATUS: begin
          RDATA[ST_EN]      = en_q;
          RDATA[ST_PAR_EN]  = par_en_q;
          RDATA[ST_PAR_ODD] = par_odd_q;
          RDATA[ST_STOP2]   = stop2_q;
          RDATA[ST_BUSY]    = busy;
          RDATA[ST_FULL]    = fifo_full;
          RDATA[ST_EMPTY]   = fifo_empty;
        end
        ADDR_INTCTL: begin
          RDATA[IC_EMPTY_IE]         = empty_ie_q;
          RDATA[IC_THR_IE]           = thr_ie_q;
          RDATA[IC_OVF_IE]           = ovf_ie_q;
          RDATA[IC_OVF]              = ovf_q;
          RDATA[IC_THRESH_LO +: 4]   = thresh_q;
        end
        ADDR_DATA: RDATA = 8'(fifo_level);
        default:   RDATA = 8'(baud_q);
      endcase
    end
  end

  // interrupt is purely from registered state
  assign thr_hit = (8'(fifo_level) <= 8'(thresh_q));
  assign NINT    = ~((empty_ie_q & fifo_empty & en_q) |
                     (thr_ie_q & thr_hit & en_q) |
                     (ovf_ie_q & ovf_q));
  assign LEVEL   = fifo_level;
  assign TX      = tx_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: queue/waveform reference model checked every cycle,
// directed scenarios with hand-derived expectations, then randomized traffic.
module tb_uart_tx_engine;

  localparam int DB = 8;
  localparam int FD = 16;
  localparam int DW = 8;
  localparam int LW = $clog2(FD) + 1;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [1:0]    ADDR = 2'd0;
  logic          NCS = 1'b1, NW = 1'b1, NO = 1'b1;
  logic [7:0]    WDATA = 8'd0;
  logic [7:0]    RDATA;
  logic          NINT;
  logic [LW-1:0] LEVEL;
  logic          TX;

  int checks = 0;
  int failures = 0;

  uart_tx_engine #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .NCS(NCS), .NW(NW), .NO(NO),
    .WDATA(WDATA), .RDATA(RDATA), .NINT(NINT), .LEVEL(LEVEL), .TX(TX)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic       m_en, m_pe, m_po, m_s2, m_eie, m_tie, m_oie, m_ovf;
  logic [3:0] m_thresh;
  logic [7:0] m_baud;
  int         q[$];      // bytes waiting in the FIFO
  bit         plan[$];   // TX level for each upcoming cycle of the frame in flight

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void start_frame(int b);
    logic [7:0] bb;
    bit bits[$];
    bb = 8'(b);
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(bb[i]);
    if (m_pe) bits.push_back(m_po ? ~(^bb) : ^bb);
    bits.push_back(1'b1);
    if (m_s2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k <= int'(m_baud); k++) plan.push_back(bits[i]);
  endfunction

  function automatic int exp_tx();
    return (plan.size() > 0) ? int'(plan[0]) : 1;
  endfunction

  function automatic int exp_nint();
    bit cause;
    cause = (m_eie && q.size() == 0 && m_en) ||
            (m_tie && q.size() <= int'(m_thresh) && m_en) ||
            (m_oie && m_ovf);
    return cause ? 0 : 1;
  endfunction

  function automatic int exp_rdata();
    logic [7:0] r;
    r = 8'h00;
    if (!NCS && !NO) begin
      case (ADDR)
        2'd0: r = {q.size() == 0, q.size() == FD, plan.size() != 0, 1'b0, m_s2, m_po, m_pe, m_en};
        2'd1: r = {m_thresh, m_ovf, m_oie, m_tie, m_eie};
        2'd2: r = 8'(q.size());
        default: r = m_baud;
      endcase
    end
    return int'(r);
  endfunction

  // model advances on every edge using the values that were visible before it
  always @(posedge CLK or posedge RESET) begin : model
    logic       wr, pop, flush, push;
    logic [7:0] d;
    int         qs;
    if (RESET) begin
      {m_en, m_pe, m_po, m_s2, m_eie, m_tie, m_oie, m_ovf} = '0;
      m_thresh = '0;
      m_baud   = '0;
      q.delete();
      plan.delete();
    end else begin
      wr    = !NCS && !NW;
      d     = WDATA;
      qs    = q.size();
      pop   = (plan.size() == 0) && m_en && (qs > 0);
      flush = wr && ADDR == 2'd0 && d[4];
      push  = wr && ADDR == 2'd2 && m_en;
      if (plan.size() > 0) void'(plan.pop_front());
      else if (pop) start_frame(q.pop_front());
      if (flush) q.delete();
      else if (push) begin
        if (qs < FD || pop) q.push_back(int'(d));
        else m_ovf = 1'b1;
      end
      if (wr && ADDR == 2'd0) {m_s2, m_po, m_pe, m_en} = d[3:0];
      if (wr && ADDR == 2'd1) begin
        {m_oie, m_tie, m_eie} = d[2:0];
        m_thresh = d[7:4];
        if (d[3]) m_ovf = 1'b0;
      end
      if (wr && ADDR == 2'd3 && !m_en) m_baud = d;
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      check("tx", TX, exp_tx());
      check("level", LEVEL, q.size());
      check("nint", NINT, exp_nint());
      check("rdata", RDATA, exp_rdata());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(int n);
    repeat (n) begin
      @(posedge CLK); #2;
      NCS = ($urandom_range(0, 7) == 0);
      NW = 1'b1; NO = 1'b0;
      ADDR = 2'($urandom_range(0, 3));
      WDATA = 8'($urandom);
    end
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    @(posedge CLK); #2;
    NCS = 1'b0; NW = 1'b0; NO = 1'b1; ADDR = a; WDATA = d;
  endtask

  task automatic rd(logic [1:0] a);
    @(posedge CLK); #2;
    NCS = 1'b0; NW = 1'b1; NO = 1'b0; ADDR = a;
  endtask

  // BAUD write only while nothing is in flight, so a frame never sees a mid-frame divisor change
  task automatic wr_baud_safe(logic [7:0] d);
    @(posedge CLK); #2;
    if (plan.size() == 0 && !m_en) begin
      NCS = 1'b0; NW = 1'b0; NO = 1'b1; ADDR = 2'd3; WDATA = d;
    end else begin
      NCS = 1'b0; NW = 1'b1; NO = 1'b0; ADDR = 2'd2;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #2;
    RESET = 1'b1; NCS = 1'b1; NW = 1'b1; NO = 1'b1;
    #1;
    check("rst_tx", TX, 1);
    check("rst_level", LEVEL, 0);
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
  endtask

  task automatic wait_tx(logic v, int max, string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < max; n++) begin
      @(negedge CLK);
      if (TX === v) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_level(int v, int max, string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < max; n++) begin
      @(negedge CLK);
      if (int'(LEVEL) == v) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  // sample one cycle into each bit, `nb` bits of `bits_per` cycles each
  task automatic check_frame(logic [11:0] seq, int nb, int bits_per, string name);
    for (int k = 0; k < nb; k++) begin
      check(name, TX, seq[k]);
      repeat (bits_per) @(negedge CLK);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d;
    int r;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;

    // reset state
    rd(2'd0);
    @(negedge CLK);
    check("rst_status", RDATA, 8'h80);
    check("rst_nint", NINT, 1);
    check("rst_txidle", TX, 1);
    check("rst_lvl0", LEVEL, 0);

    // 0xA5 at BAUD=3: start, LSB-first data, stop; 4 cycles per bit
    wr(2'd3, 8'd3);
    wr(2'd0, 8'h01);
    wr(2'd2, 8'hA5);
    idle(1);
    wait_tx(1'b0, 20, "a5_start_seen");
    check_frame({2'b00, 10'b1_10100101_0}, 10, 4, "a5_bits");

    // even parity, two stop bits: 0x07 has odd popcount -> parity bit 1
    wr(2'd0, 8'h0B);
    wr(2'd2, 8'h07);
    idle(1);
    wait_tx(1'b0, 20, "par_even_start_seen");
    check_frame({2'b11, 1'b1, 8'h07, 1'b0}, 12, 4, "par_even_bits");
    // odd parity -> parity bit 0
    wr(2'd0, 8'h0F);
    wr(2'd2, 8'h07);
    idle(1);
    wait_tx(1'b0, 20, "par_odd_start_seen");
    check_frame({2'b11, 1'b0, 8'h07, 1'b0}, 12, 4, "par_odd_bits");
    idle(4);

    // overflow: BAUD=255 keeps the serializer busy; first byte leaves the FIFO
    // for the shift register, so 18 writes fill 16 slots and drop one
    wr(2'd0, 8'h00);
    wr(2'd3, 8'hFF);
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h04);
    repeat (18) wr(2'd2, 8'($urandom));
    idle(1);
    @(negedge CLK);
    check("ovf_level16", LEVEL, 16);
    check("ovf_nint_low", NINT, 0);
    wr(2'd1, 8'h0C);
    idle(1);
    @(negedge CLK);
    check("ovf_clr_nint_high", NINT, 1);
    do_reset();

    // threshold interrupt: THRESH=2, 4 waiting bytes
    wr(2'd3, 8'd7);
    wr(2'd1, 8'h22);
    wr(2'd0, 8'h01);
    repeat (5) wr(2'd2, 8'($urandom));
    idle(1);
    @(negedge CLK);
    check("thr_level4", LEVEL, 4);
    check("thr_nint_high", NINT, 1);
    wait_level(2, 400, "thr_drain_to2");
    check("thr_nint_low", NINT, 0);
    do_reset();

    // flush mid-frame with 5 queued
    wr(2'd3, 8'd7);
    wr(2'd0, 8'h01);
    repeat (6) wr(2'd2, 8'($urandom));
    idle(1);
    @(negedge CLK);
    check("flush_pre_level5", LEVEL, 5);
    idle(10);
    wr(2'd0, 8'h11);
    idle(1);
    @(negedge CLK);
    check("flush_level0", LEVEL, 0);
    repeat (100) @(negedge CLK);
    check("flush_tx_idle", TX, 1);
    check("flush_level_stays0", LEVEL, 0);

    // BAUD write ignored while enabled; DATA write ignored while disabled
    wr(2'd3, 8'h55);
    rd(2'd3);
    @(negedge CLK);
    check("baud_locked", RDATA, 7);
    wr(2'd0, 8'h00);
    wr(2'd2, 8'h99);
    idle(1);
    @(negedge CLK);
    check("push_dis_level", LEVEL, 0);
    // reset in the middle of a data bit
    wr(2'd0, 8'h01);
    repeat (3) wr(2'd2, 8'($urandom));
    idle(1);
    wait_tx(1'b0, 40, "rst_mid_start_seen");
    repeat (10) @(negedge CLK);
    do_reset();

    // randomized traffic
    wr_baud_safe(8'($urandom_range(0, 3)));
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) wr(2'd2, 8'($urandom));
      else if (r <= 5) begin
        d = 8'($urandom);
        d[4] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        wr(2'd0, d);
      end
      else if (r == 6) wr(2'd1, 8'($urandom));
      else if (r == 7) wr_baud_safe(8'($urandom_range(0, 3)));
      else idle($urandom_range(1, 15));
    end
    idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
